control: RTL and testbench
==========================

CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter WORD, default 32: width of the register operands; taken from the shared `WORD constant.
REQ-002 clk  in  1  single clock; rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 op  in  6  instruction[31:26].
REQ-005 funct  in  6  instruction[5:0]; used only when op=000000.
REQ-006 harzard  in  1  stall request from the hazard unit; 1 = insert a bubble.
REQ-007 reg_rs_d, reg_rt_d  in  WORD  forwarded rs/rt values for the branch compare.
REQ-008 is_immd  out  1  1 = ALU operand 2 is sign-extended imm16, and the destination is rt.
REQ-009 only_shamt  out  1  1 = ALU operand 1 is zero-extended shamt (sll/srl/sra).
REQ-010 mem_w, mem_r  out  1  data-memory write / read enables.
REQ-011 alu_op  out  4  ALU operation code.
REQ-012 wb_en  out  1  register write-back enable.
REQ-013 branch_taken, jump_taken  out  1  redirect the PC.
REQ-014 terminate  out  1  halt request.
REQ-015 is_branch  out  1  instruction is beq/bne; the hazard unit uses it.
REQ-016 is_jal, is_jr  out  1  jal (destination is r31) / jr (target taken from rs).

Function
REQ-017 Decode SHALL be combinational from op/funct/harzard/reg_*_d; the only state is the halt flag.
REQ-018 alu_op codes SHALL be: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9, ADDU=10, SUBU=11, NOP=15.
REQ-019 R-type (op=000000) decode SHALL be as follows; all set wb_en=1, is_immd=0.
- funct 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt: matching alu_op.
- sll 000000, srl 000010, sra 000011: SLL/SRL/SRA with only_shamt=1.
- sllv 000100, srlv 000110, srav 000111: SLL/SRL/SRA with only_shamt=0.
REQ-020 jr (op=0, funct=001000) SHALL set jump_taken=1, is_jr=1, wb_en=0, alu_op=NOP.
REQ-021 The I-type group SHALL decode with is_immd=1 and wb_en=1.
- addi 001000: ADD.
- addiu 001001: ADDU.
- andi 001100: AND.
- ori 001101: OR.
- xori 001110: XOR.
REQ-022 lw 100011 SHALL decode as is_immd=1, mem_r=1, wb_en=1, alu_op=ADD.
REQ-023 sw 101011 SHALL decode as is_immd=1, mem_w=1, wb_en=0, alu_op=ADD.
REQ-024 beq 000100 / bne 000101 SHALL set is_branch=1 and branch_taken=(reg_rs_d==reg_rt_d) / (reg_rs_d!=reg_rt_d); the compare is a full WORD-bit equality.
REQ-025 j 000010 SHALL set jump_taken=1; jal 000011 SHALL set jump_taken=1, is_jal=1, wb_en=1.
REQ-026 op=111111 SHALL assert terminate.
REQ-027 Undefined op/funct SHALL produce a bubble: all 1-bit outputs 0, alu_op=NOP.
REQ-028 Any output not named for an instruction SHALL be 0.
REQ-029 harzard=1 SHALL force mem_w, mem_r, wb_en, branch_taken, jump_taken, is_jal, is_jr and the decoded terminate to 0, and alu_op to NOP.
REQ-030 During harzard=1, is_immd, only_shamt and is_branch SHALL still follow decode, so the stall persists through branch hazards.
REQ-031 Halt flag: set on a rising clk when terminate is decoded with harzard=0; cleared only by reset.
REQ-032 terminate output SHALL equal the decoded terminate OR the halt flag.

Reset
REQ-033 rst=0 SHALL clear the halt flag asynchronously and force all outputs to the bubble value (0, alu_op=NOP) for as long as rst=0.
REQ-034 After rst rises, outputs SHALL follow decode combinationally with no latency.

Structure
REQ-035 `WORD and the alu_op code constants SHALL live in the shared constants.v, which control and the ALU both include.
REQ-036 control SHALL have no sub-modules.
REQ-037 Companion leaf data_mux SHALL be delivered in the same file: sel 1, in1/in2 WORD, out WORD; out = sel ? in2 : in1.
REQ-038 Companion leaf data_mux_4 SHALL be delivered in the same file: sel 2, in1..in4 WORD, out WORD; out = in1/in2/in3/in4 for sel 0/1/2/3.

Verification
REQ-039 add: op=000000, funct=100000, harzard=0 -> alu_op=0, wb_en=1; is_immd=0, only_shamt=0, mem_*=0.
REQ-040 beq: op=000100 with rs_d=rt_d=0x0000_1234 -> branch_taken=1, is_branch=1; rt_d=0x8000_1234 -> branch_taken=0.
REQ-041 lw (op=100011) with harzard=1 -> mem_r=0, wb_en=0, alu_op=15, is_immd=1; same op with harzard=0 -> mem_r=1, alu_op=0.
REQ-042 terminate: op=111111 and one clk edge, then op=000000/funct=100000 -> terminate stays 1; rst pulsed low -> terminate=0.
REQ-043 shift: funct=000000 -> only_shamt=1, alu_op=7; jal (op=000011) -> is_jal=1, jump_taken=1, wb_en=1.
REQ-044 data_mux_4: sel=0..3 with inputs 0x11, 0x22, 0x33, 0x44 -> out=0x11, 0x22, 0x33, 0x44.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants for the control unit and its datapath companions:
// operand width, ALU operation codes, opcode/funct encodings and the
// packed bundle of control signals.
package control_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ADDU = 4'd10,
        ALU_SUBU = 4'd11,
        ALU_NOP  = 4'd15
    } alu_op_t;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type function codes, instruction[5:0]
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef struct packed {
        logic    is_immd;
        logic    only_shamt;
        logic    mem_w;
        logic    mem_r;
        alu_op_t alu_op;
        logic    wb_en;
        logic    branch_taken;
        logic    jump_taken;
        logic    terminate;
        logic    is_branch;
        logic    is_jal;
        logic    is_jr;
    } ctrl_t;

    // The bubble: nothing enabled, ALU idle
    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_NOP;
        return c;
    endfunction

endpackage

// File: rtl/control.sv
// Main decoder for the pipeline ID stage plus its two datapath mux leaves.
// Everything is combinational except the sticky halt flag.
module control
    import control_pkg::*;
#(
    parameter int WORD = WORD_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            harzard,
    input  logic [WORD-1:0] reg_rs_d,
    input  logic [WORD-1:0] reg_rt_d,
    output logic            is_immd,
    output logic            only_shamt,
    output logic            mem_w,
    output logic            mem_r,
    output logic [3:0]      alu_op,
    output logic            wb_en,
    output logic            branch_taken,
    output logic            jump_taken,
    output logic            terminate,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jr
);

    ctrl_t dec;
    ctrl_t ctl;
    logic  halt;

    // Raw instruction decode; outputs an instruction does not name stay 0
    always_comb begin
        // NOTE: every field gets a default before the case so no path can
        // leave a bit unassigned and infer a latch.
        dec = ctrl_bubble();
        case (op)
            OP_RTYPE: begin
                dec.wb_en = 1'b1;
                case (funct)
                    F_ADD:  dec.alu_op = ALU_ADD;
                    F_ADDU: dec.alu_op = ALU_ADDU;
                    F_SUB:  dec.alu_op = ALU_SUB;
                    F_SUBU: dec.alu_op = ALU_SUBU;
                    F_AND:  dec.alu_op = ALU_AND;
                    F_OR:   dec.alu_op = ALU_OR;
                    F_XOR:  dec.alu_op = ALU_XOR;
                    F_NOR:  dec.alu_op = ALU_NOR;
                    F_SLT:  dec.alu_op = ALU_SLT;
                    F_SLL:  begin dec.alu_op = ALU_SLL; dec.only_shamt = 1'b1; end
                    F_SRL:  begin dec.alu_op = ALU_SRL; dec.only_shamt = 1'b1; end
                    F_SRA:  begin dec.alu_op = ALU_SRA; dec.only_shamt = 1'b1; end
                    F_SLLV: dec.alu_op = ALU_SLL;
                    F_SRLV: dec.alu_op = ALU_SRL;
                    F_SRAV: dec.alu_op = ALU_SRA;
                    F_JR: begin
                        dec.wb_en      = 1'b0;
                        dec.jump_taken = 1'b1;
                        dec.is_jr      = 1'b1;
                    end
                    default: dec.wb_en = 1'b0;   // unknown funct: bubble
                endcase
            end
            OP_ADDI:  begin dec.is_immd = 1'b1; dec.wb_en = 1'b1; dec.alu_op = ALU_ADD;  end
            OP_ADDIU: begin dec.is_immd = 1'b1; dec.wb_en = 1'b1; dec.alu_op = ALU_ADDU; end
            OP_ANDI:  begin dec.is_immd = 1'b1; dec.wb_en = 1'b1; dec.alu_op = ALU_AND;  end
            OP_ORI:   begin dec.is_immd = 1'b1; dec.wb_en = 1'b1; dec.alu_op = ALU_OR;   end
            OP_XORI:  begin dec.is_immd = 1'b1; dec.wb_en = 1'b1; dec.alu_op = ALU_XOR;  end
            OP_LW: begin
                dec.is_immd = 1'b1;
                dec.mem_r   = 1'b1;
                dec.wb_en   = 1'b1;
                dec.alu_op  = ALU_ADD;
            end
            OP_SW: begin
                dec.is_immd = 1'b1;
                dec.mem_w   = 1'b1;
                dec.alu_op  = ALU_ADD;
            end
            // Branches, jumps and halt do not use the ALU; alu_op is left at 0
            OP_BEQ: begin
                dec.is_branch    = 1'b1;
                dec.branch_taken = (reg_rs_d == reg_rt_d);
                dec.alu_op       = ALU_ADD;
            end
            OP_BNE: begin
                dec.is_branch    = 1'b1;
                dec.branch_taken = (reg_rs_d != reg_rt_d);
                dec.alu_op       = ALU_ADD;
            end
            OP_J: begin
                dec.jump_taken = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_JAL: begin
                dec.jump_taken = 1'b1;
                dec.is_jal     = 1'b1;
                dec.wb_en      = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_HALT: begin
                dec.terminate = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            default: dec = ctrl_bubble();
        endcase
    end

    // Sticky halt: once a halt retires unstalled, only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst) begin
            halt <= 1'b0;
        end else if (dec.terminate && !harzard) begin
            halt <= 1'b1;
        end
    end

    // Stall squash, halt merge and reset override
    always_comb begin
        ctl = dec;
        if (harzard) begin
            // Operand-select and is_branch keep following decode so the
            // hazard unit still sees the branch it is stalling on.
            ctl              = ctrl_bubble();
            ctl.is_immd      = dec.is_immd;
            ctl.only_shamt   = dec.only_shamt;
            ctl.is_branch    = dec.is_branch;
        end
        ctl.terminate = (dec.terminate && !harzard) || halt;
        if (!rst) begin
            ctl = ctrl_bubble();
        end
    end

    assign is_immd      = ctl.is_immd;
    assign only_shamt   = ctl.only_shamt;
    assign mem_w        = ctl.mem_w;
    assign mem_r        = ctl.mem_r;
    assign alu_op       = ctl.alu_op;
    assign wb_en        = ctl.wb_en;
    assign branch_taken = ctl.branch_taken;
    assign jump_taken   = ctl.jump_taken;
    assign terminate    = ctl.terminate;
    assign is_branch    = ctl.is_branch;
    assign is_jal       = ctl.is_jal;
    assign is_jr        = ctl.is_jr;

endmodule

// Two-way operand mux: out = sel ? in2 : in1
module data_mux
    import control_pkg::*;
#(
    parameter int WORD = WORD_BITS
) (
    input  logic            sel,
    input  logic [WORD-1:0] in1,
    input  logic [WORD-1:0] in2,
    output logic [WORD-1:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// Four-way operand mux: sel 0..3 picks in1..in4
module data_mux_4
    import control_pkg::*;
#(
    parameter int WORD = WORD_BITS
) (
    input  logic [1:0]      sel,
    input  logic [WORD-1:0] in1,
    input  logic [WORD-1:0] in2,
    input  logic [WORD-1:0] in3,
    input  logic [WORD-1:0] in4,
    output logic [WORD-1:0] out
);

    // Plain select; every sel value is covered so no latch is possible
    always_comb begin
        case (sel)
            2'd0:    out = in1;
            2'd1:    out = in2;
            2'd2:    out = in3;
            default: out = in4;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control and its mux leaves: directed cases first,
// then randomized decode traffic against a table-driven reference model.
module tb_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        harzard;
    logic [31:0] reg_rs_d;
    logic [31:0] reg_rt_d;
    logic        is_immd, only_shamt, mem_w, mem_r, wb_en;
    logic        branch_taken, jump_taken, terminate, is_branch, is_jal, is_jr;
    logic [3:0]  alu_op;

    logic        m2_sel;
    logic [1:0]  m4_sel;
    logic [31:0] m_in1, m_in2, m_in3, m_in4, m2_out, m4_out;

    int checks   = 0;
    int failures = 0;

    // Reference tables: ALU code by R-type funct / by I-type opcode
    int r_alu[int];
    int i_alu[int];
    bit halted;

    logic [14:0] ctrl_vec;
    assign ctrl_vec = {is_immd, only_shamt, mem_w, mem_r, alu_op, wb_en,
                       branch_taken, jump_taken, terminate, is_branch, is_jal, is_jr};

    control dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .harzard(harzard),
        .reg_rs_d(reg_rs_d), .reg_rt_d(reg_rt_d),
        .is_immd(is_immd), .only_shamt(only_shamt), .mem_w(mem_w), .mem_r(mem_r),
        .alu_op(alu_op), .wb_en(wb_en), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .terminate(terminate), .is_branch(is_branch),
        .is_jal(is_jal), .is_jr(is_jr)
    );

    data_mux u_mux2 (.sel(m2_sel), .in1(m_in1), .in2(m_in2), .out(m2_out));

    data_mux_4 u_mux4 (.sel(m4_sel), .in1(m_in1), .in2(m_in2), .in3(m_in3),
                       .in4(m_in4), .out(m4_out));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected control vector from the instruction rules
    function automatic logic [14:0] expect_ctrl(logic rst_v, bit hlt, logic [5:0] o,
                                                logic [5:0] f, logic hz,
                                                logic [31:0] rs, logic [31:0] rt);
        logic ii, sh, mw, mr, wb, bt, jt, tm, br, jl, jrr;
        logic [3:0] ao;
        {ii, sh, mw, mr, wb, bt, jt, tm, br, jl, jrr} = '0;
        ao = 4'd15;
        if (o == 6'h00) begin
            if (r_alu.exists(int'(f))) begin
                wb = 1; ao = 4'(r_alu[int'(f)]);
                sh = (f inside {6'h00, 6'h02, 6'h03});
            end else if (f == 6'h08) begin
                jt = 1; jrr = 1;
            end
        end else if (i_alu.exists(int'(o))) begin
            ii = 1; wb = 1; ao = 4'(i_alu[int'(o)]);
        end else begin
            case (o)
                6'h23: begin ii = 1; mr = 1; wb = 1; ao = 0; end
                6'h2B: begin ii = 1; mw = 1; ao = 0; end
                6'h04: begin br = 1; bt = (rs == rt); ao = 0; end
                6'h05: begin br = 1; bt = (rs != rt); ao = 0; end
                6'h02: begin jt = 1; ao = 0; end
                6'h03: begin jt = 1; jl = 1; wb = 1; ao = 0; end
                6'h3F: begin tm = 1; ao = 0; end
                default: ;
            endcase
        end
        if (hz) begin
            {mw, mr, wb, bt, jt, jl, jrr, tm} = '0;
            ao = 4'd15;
        end
        tm = tm | hlt;
        if (!rst_v) begin
            {ii, sh, mw, mr, wb, bt, jt, tm, br, jl, jrr} = '0;
            ao = 4'd15;
        end
        return {ii, sh, mw, mr, ao, wb, bt, jt, tm, br, jl, jrr};
    endfunction

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic hz,
                         input logic [31:0] rs, input logic [31:0] rt);
        op = o; funct = f; harzard = hz; reg_rs_d = rs; reg_rt_d = rt;
    endtask

    localparam logic [5:0] VALID_OPS [12] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
                                              6'h05, 6'h08, 6'h09, 6'h0C, 6'h23, 6'h2B};
    localparam logic [5:0] VALID_FN [16]  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                              6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                              6'h25, 6'h26, 6'h27, 6'h2A};

    initial begin
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  o;
        logic [5:0]  f;
        logic [31:0] mux_vals [4];

        r_alu[32'h20] = 0;  r_alu[32'h21] = 10; r_alu[32'h22] = 1;  r_alu[32'h23] = 11;
        r_alu[32'h24] = 2;  r_alu[32'h25] = 3;  r_alu[32'h26] = 4;  r_alu[32'h27] = 5;
        r_alu[32'h2A] = 6;  r_alu[32'h00] = 7;  r_alu[32'h02] = 8;  r_alu[32'h03] = 9;
        r_alu[32'h04] = 7;  r_alu[32'h06] = 8;  r_alu[32'h07] = 9;
        i_alu[32'h08] = 0;  i_alu[32'h09] = 10; i_alu[32'h0C] = 2;
        i_alu[32'h0D] = 3;  i_alu[32'h0E] = 4;

        // Reset holds the bubble even with lw presented
        rst = 1'b0;
        drive(6'h23, 6'h00, 1'b0, 32'h0, 32'h0);
        m2_sel = 1'b0; m4_sel = 2'd0;
        m_in1 = 32'h11; m_in2 = 32'h22; m_in3 = 32'h33; m_in4 = 32'h44;
        #12;
        check("rst_alu_op", 32'(alu_op), 32'd15);
        check("rst_vec", 32'(ctrl_vec), 32'h0780);

        // Decode follows immediately after reset release
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("lw_mem_r", 32'(mem_r), 32'd1);
        check("lw_alu_op", 32'(alu_op), 32'd0);
        check("lw_wb_en", 32'(wb_en), 32'd1);
        harzard = 1'b1; #1;
        check("lw_hz_mem_r", 32'(mem_r), 32'd0);
        check("lw_hz_wb_en", 32'(wb_en), 32'd0);
        check("lw_hz_alu_op", 32'(alu_op), 32'd15);
        check("lw_hz_is_immd", 32'(is_immd), 32'd1);

        drive(6'h00, 6'h20, 1'b0, 32'h0, 32'h0); #1;
        check("add_alu_op", 32'(alu_op), 32'd0);
        check("add_vec", 32'(ctrl_vec), {17'h0, 15'b0000_0000_1000000});

        drive(6'h04, 6'h00, 1'b0, 32'h0000_1234, 32'h0000_1234); #1;
        check("beq_eq_taken", 32'(branch_taken), 32'd1);
        check("beq_eq_is_branch", 32'(is_branch), 32'd1);
        reg_rt_d = 32'h8000_1234; #1;
        check("beq_ne_taken", 32'(branch_taken), 32'd0);
        check("beq_ne_is_branch", 32'(is_branch), 32'd1);

        drive(6'h00, 6'h00, 1'b0, 32'h0, 32'h0); #1;
        check("sll_shamt", 32'(only_shamt), 32'd1);
        check("sll_alu_op", 32'(alu_op), 32'd7);
        drive(6'h03, 6'h00, 1'b0, 32'h0, 32'h0); #1;
        check("jal_flags", 32'({is_jal, jump_taken, wb_en}), 32'b111);

        // Halt is sticky across later instructions until reset
        @(posedge clk); #1 drive(6'h3F, 6'h00, 1'b0, 32'h0, 32'h0);
        #1 check("halt_decoded", 32'(terminate), 32'd1);
        @(posedge clk); #1 drive(6'h00, 6'h20, 1'b0, 32'h0, 32'h0);
        #1 check("halt_sticky", 32'(terminate), 32'd1);
        check("halt_add_alu", 32'(alu_op), 32'd0);
        rst = 1'b0; #1;
        check("halt_rst_low", 32'(terminate), 32'd0);
        rst = 1'b1; #1;
        check("halt_cleared", 32'(terminate), 32'd0);

        // Mux leaves
        mux_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int s = 0; s < 4; s++) begin
            m4_sel = 2'(s); #1;
            check($sformatf("mux4_sel%0d", s), m4_out, mux_vals[s]);
        end
        m2_sel = 1'b0; #1 check("mux2_sel0", m2_out, 32'h11);
        m2_sel = 1'b1; #1 check("mux2_sel1", m2_out, 32'h22);

        // Randomized traffic against the model, halt tracked cycle by cycle
        halted = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 99) < 80)
                o = VALID_OPS[$urandom_range(0, 11)];
            else if ($urandom_range(0, 19) == 0)
                o = 6'h3F;
            else
                o = 6'($urandom);
            f  = ($urandom_range(0, 99) < 85) ? VALID_FN[$urandom_range(0, 15)]
                                              : 6'($urandom);
            rs = $urandom;
            case ($urandom_range(0, 2))
                0:       rt = rs;
                1:       rt = rs ^ (32'h1 << $urandom_range(0, 31));
                default: rt = $urandom;
            endcase
            drive(o, f, ($urandom_range(0, 3) == 0), rs, rt);
            if (!rst) halted = 1'b0;
            @(negedge clk);
            check($sformatf("rand%0d_op%0h_fn%0h_hz%0d", i, op, funct, harzard),
                  32'(ctrl_vec),
                  32'(expect_ctrl(rst, halted, op, funct, harzard, reg_rs_d, reg_rt_d)));
            if (rst && op == 6'h3F && !harzard) halted = 1'b1;
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
